// File: rtl/bp_iter_ctrl_if.sv
// bp_iter_ctrl_if: host/datapath handshake bundle for the iteration sequencer.
// master = sequencer side, slave = host/datapath side.
// Signals: start/abort (host), h_rd_en/h_rd_addr (H load), col_* (alpha
// AXI-S beats), res_tvalid (result strobes), core_clr, iter_cnt, busy, done,
// timeout_err.
interface bp_iter_ctrl_if #(
    parameter int I        = 7,
    parameter int A        = 2,
    parameter int MAX_ITER = 8
);
    logic                          start;
    logic                          abort;
    logic                          h_rd_en;
    logic [$clog2(I):0]            h_rd_addr;
    logic                          col_tvalid;
    logic                          col_tready;
    logic                          col_tlast;
    logic [$clog2(A):0]            col_idx;
    logic                          col_src_sel;
    logic                          res_tvalid;
    logic                          core_clr;
    logic [$clog2(MAX_ITER+1)-1:0] iter_cnt;
    logic                          busy;
    logic                          done;
    logic                          timeout_err;

    modport master (
        input  start, abort, col_tready, res_tvalid,
        output h_rd_en, h_rd_addr, col_tvalid, col_tlast, col_idx,
        output col_src_sel, core_clr, iter_cnt, busy, done, timeout_err
    );

    modport slave (
        output start, abort, col_tready, res_tvalid,
        input  h_rd_en, h_rd_addr, col_tvalid, col_tlast, col_idx,
        input  col_src_sel, core_clr, iter_cnt, busy, done, timeout_err
    );
endinterface

// File: rtl/bp_iter_ctrl.sv
// bp_iter_ctrl: iteration sequencer for the message-passing core array.
// Loads I H rows, streams A alpha beats per iteration, collects J result
// strobes, clears the cores between iterations, stops after MAX_ITER.
// Ports: clk, rst_n (async, active-low), bus (bp_iter_ctrl_if.master).
// Optional macro BP_ITER_CTRL_TIMEOUT_EN adds a WAIT_RES watchdog (TIMEOUT).
module bp_iter_ctrl #(
    parameter int J        = 14,
    parameter int I        = 7,
    parameter int A        = 2,
    parameter int MAX_ITER = 8,
    parameter int TIMEOUT  = 1023
) (
    input  logic           clk,
    input  logic           rst_n,
    bp_iter_ctrl_if.master bus
);
    localparam int AW = $clog2(I) + 1;
    localparam int CW = $clog2(A) + 1;
    localparam int IW = $clog2(MAX_ITER + 1);
    localparam int RW = $clog2(J + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_H, S_SEND_COL, S_WAIT_RES, S_CLEAR, S_DONE
    } state_t;

    state_t          r_state;
    logic            r_h_rd_en;
    logic [AW-1:0]   r_h_rd_addr;
    logic            r_col_tvalid;
    logic            r_col_tlast;
    logic [CW-1:0]   r_col_idx;
    logic            r_col_src_sel;
    logic            r_core_clr;
    logic [IW-1:0]   r_iter_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_timeout_err;
    logic [RW-1:0]   r_res_cnt;

    logic            w_hs;
    logic            w_last_res;
    logic [IW-1:0]   w_iter_nxt;
    logic            w_wd_hit;

    assign w_hs       = r_col_tvalid && bus.col_tready;
    assign w_last_res = bus.res_tvalid && (r_res_cnt == RW'(J - 1));
    assign w_iter_nxt = r_iter_cnt + IW'(1);

`ifdef BP_ITER_CTRL_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] r_wd_cnt;

    // Fires on the TIMEOUT-th silent cycle since the last strobe or entry.
    assign w_wd_hit = (r_state == S_WAIT_RES) && !bus.res_tvalid &&
                      (r_wd_cnt == WW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_wd_cnt <= '0;
        else if (r_state != S_WAIT_RES || bus.res_tvalid)
            r_wd_cnt <= '0;
        else if (r_wd_cnt != WW'(TIMEOUT - 1))
            r_wd_cnt <= r_wd_cnt + WW'(1);
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_wd_hit         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_h_rd_en     <= 1'b0;
            r_h_rd_addr   <= '0;
            r_col_tvalid  <= 1'b0;
            r_col_tlast   <= 1'b0;
            r_col_idx     <= '0;
            r_col_src_sel <= 1'b0;
            r_core_clr    <= 1'b0;
            r_iter_cnt    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_res_cnt     <= '0;
        end else begin
            r_core_clr <= 1'b0;
            r_done     <= 1'b0;
            if (r_state != S_IDLE && (bus.abort || w_wd_hit)) begin
                // Abort and watchdog both drop the run and clear the cores.
                r_state      <= S_IDLE;
                r_core_clr   <= 1'b1;
                r_h_rd_en    <= 1'b0;
                r_col_tvalid <= 1'b0;
                r_col_tlast  <= 1'b0;
                r_busy       <= 1'b0;
                if (!bus.abort)
                    r_timeout_err <= 1'b1;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            r_state       <= S_LOAD_H;
                            r_busy        <= 1'b1;
                            r_h_rd_en     <= 1'b1;
                            r_h_rd_addr   <= '0;
                            r_iter_cnt    <= '0;
                            r_timeout_err <= 1'b0;
                        end
                    end
                    S_LOAD_H: begin
                        if (r_h_rd_addr == AW'(I - 1)) begin
                            r_h_rd_en     <= 1'b0;
                            r_state       <= S_SEND_COL;
                            r_col_tvalid  <= 1'b1;
                            r_col_idx     <= '0;
                            r_col_tlast   <= (A == 1);
                            r_col_src_sel <= (r_iter_cnt != '0);
                        end else begin
                            r_h_rd_addr <= r_h_rd_addr + AW'(1);
                        end
                    end
                    S_SEND_COL: begin
                        if (w_hs) begin
                            if (r_col_tlast) begin
                                r_col_tvalid <= 1'b0;
                                r_col_tlast  <= 1'b0;
                                r_res_cnt    <= '0;
                                r_state      <= S_WAIT_RES;
                            end else begin
                                r_col_idx   <= r_col_idx + CW'(1);
                                r_col_tlast <= (r_col_idx + CW'(1) == CW'(A - 1));
                            end
                        end
                    end
                    S_WAIT_RES: begin
                        if (w_last_res) begin
                            r_res_cnt  <= RW'(J);
                            r_iter_cnt <= w_iter_nxt;
                            if (w_iter_nxt == IW'(MAX_ITER)) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state    <= S_CLEAR;
                                r_core_clr <= 1'b1;
                            end
                        end else if (bus.res_tvalid) begin
                            r_res_cnt <= r_res_cnt + RW'(1);
                        end
                    end
                    S_CLEAR: begin
                        r_state       <= S_SEND_COL;
                        r_col_tvalid  <= 1'b1;
                        r_col_idx     <= '0;
                        r_col_tlast   <= (A == 1);
                        r_col_src_sel <= (r_iter_cnt != '0);
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.h_rd_en     = r_h_rd_en;
    assign bus.h_rd_addr   = r_h_rd_addr;
    assign bus.col_tvalid  = r_col_tvalid;
    assign bus.col_tlast   = r_col_tlast;
    assign bus.col_idx     = r_col_idx;
    assign bus.col_src_sel = r_col_src_sel;
    assign bus.core_clr    = r_core_clr;
    assign bus.iter_cnt    = r_iter_cnt;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_bp_iter_ctrl.sv
// tb_bp_iter_ctrl: directed self-checking bench for bp_iter_ctrl
// (J=14, I=7, A=2, MAX_ITER=3, TIMEOUT=50).
module tb_bp_iter_ctrl;
    localparam int J  = 14;
    localparam int I  = 7;
    localparam int A  = 2;
    localparam int MI = 3;
    localparam int TO = 50;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    int m_h = 0, m_hs = 0, m_clr = 0, m_done = 0;
    int b_h, b_hs, b_clr, b_done;

    bp_iter_ctrl_if #(.I(I), .A(A), .MAX_ITER(MI)) bus ();

    bp_iter_ctrl #(
        .J(J), .I(I), .A(A), .MAX_ITER(MI), .TIMEOUT(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.h_rd_en)                    m_h    <= m_h + 1;
        if (bus.col_tvalid && bus.col_tready) m_hs <= m_hs + 1;
        if (bus.core_clr)                   m_clr  <= m_clr + 1;
        if (bus.done)                       m_done <= m_done + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic snap();
        b_h = m_h; b_hs = m_hs; b_clr = m_clr; b_done = m_done;
    endtask

    task automatic pulse_res(input int n);
        for (int k = 0; k < n; k++) begin
            bus.res_tvalid = 1'b1;
            tick();
        end
        bus.res_tvalid = 1'b0;
    endtask

    task automatic go_to_wait();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (I) tick();
        repeat (A) tick();
    endtask

    task automatic col_iter(input logic src);
        chk("beat0_valid", bus.col_tvalid, 1);
        chk("beat0_idx", bus.col_idx, 0);
        chk("beat0_last", bus.col_tlast, 0);
        chk("beat0_src", bus.col_src_sel, src);
        tick();
        chk("beat1_valid", bus.col_tvalid, 1);
        chk("beat1_idx", bus.col_idx, 1);
        chk("beat1_last", bus.col_tlast, 1);
        chk("beat1_src", bus.col_src_sel, src);
        tick();
        chk("col_drop", bus.col_tvalid, 0);
        repeat (20) tick();
        chk("wait_no_clr", bus.core_clr, 0);
        pulse_res(J);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.col_tready = 1'b1;
        bus.res_tvalid = 1'b0;
        repeat (2) tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_h_en", bus.h_rd_en, 0);
        chk("rst_valid", bus.col_tvalid, 0);
        chk("rst_clr", bus.core_clr, 0);
        chk("rst_iter", bus.iter_cnt, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_to", bus.timeout_err, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", bus.busy, 0);

        // full 3-iteration run
        snap();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("run_busy", bus.busy, 1);
        for (int k = 0; k < I; k++) begin
            chk("h_en", bus.h_rd_en, 1);
            chk("h_addr", bus.h_rd_addr, k);
            tick();
        end
        chk("h_end", bus.h_rd_en, 0);
        col_iter(1'b0);
        chk("it0_clr", bus.core_clr, 1);
        chk("it0_cnt", bus.iter_cnt, 1);
        tick();
        col_iter(1'b1);
        chk("it1_clr", bus.core_clr, 1);
        chk("it1_cnt", bus.iter_cnt, 2);
        tick();
        col_iter(1'b1);
        chk("it2_done", bus.done, 1);
        chk("it2_noclr", bus.core_clr, 0);
        chk("it2_cnt", bus.iter_cnt, 3);
        tick();
        chk("done_pulse", bus.done, 0);
        chk("end_busy", bus.busy, 0);
        chk("end_cnt", bus.iter_cnt, 3);
        chk("run_h_cnt", m_h - b_h, I);
        chk("run_hs_cnt", m_hs - b_hs, 3 * A);
        chk("run_clr_cnt", m_clr - b_clr, 2);
        chk("run_done_cnt", m_done - b_done, 1);

        // tready stall pattern 1,0,0,1
        snap();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (I) tick();
        bus.col_tready = 1'b1;
        tick();
        bus.col_tready = 1'b0;
        chk("stall_idx_a", bus.col_idx, 1);
        chk("stall_last_a", bus.col_tlast, 1);
        chk("stall_valid_a", bus.col_tvalid, 1);
        tick();
        chk("stall_idx_b", bus.col_idx, 1);
        chk("stall_valid_b", bus.col_tvalid, 1);
        tick();
        chk("stall_idx_c", bus.col_idx, 1);
        chk("stall_last_c", bus.col_tlast, 1);
        bus.col_tready = 1'b1;
        tick();
        chk("stall_drop", bus.col_tvalid, 0);
        chk("stall_hs_cnt", m_hs - b_hs, 2);

        // abort after 5 results of iteration 1
        pulse_res(J);
        chk("ab_it0_clr", bus.core_clr, 1);
        tick();
        repeat (A) tick();
        chk("ab_wait", bus.col_tvalid, 0);
        pulse_res(5);
        snap();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("ab_clr", bus.core_clr, 1);
        chk("ab_busy", bus.busy, 0);
        chk("ab_done", bus.done, 0);
        chk("ab_iter", bus.iter_cnt, 1);
        tick();
        chk("ab_clr_off", bus.core_clr, 0);
        chk("ab_no_done", m_done - b_done, 0);

        // rerun with spurious strobes and starts
        snap();
        bus.start = 1'b1;
        tick();
        chk("re_iter", bus.iter_cnt, 0);
        chk("re_h_en", bus.h_rd_en, 1);
        chk("re_addr", bus.h_rd_addr, 0);
        bus.res_tvalid = 1'b1;
        repeat (I) tick();
        repeat (A) tick();
        bus.res_tvalid = 1'b0;
        bus.start      = 1'b0;
        chk("sp_wait", bus.col_tvalid, 0);
        chk("sp_busy", bus.busy, 1);
        chk("sp_h_cnt", m_h - b_h, I);
        pulse_res(J - 1);
        chk("sp_13_clr", bus.core_clr, 0);
        chk("sp_13_iter", bus.iter_cnt, 0);
        pulse_res(1);
        chk("sp_14_clr", bus.core_clr, 1);
        chk("sp_14_iter", bus.iter_cnt, 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("sp_ab_busy", bus.busy, 0);
        tick();

        // start and abort together in IDLE
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("sa_busy", bus.busy, 0);
        chk("sa_h_en", bus.h_rd_en, 0);
        chk("sa_clr", bus.core_clr, 0);

        // watchdog
        go_to_wait();
        pulse_res(J - 1);
`ifdef BP_ITER_CTRL_TIMEOUT_EN
        repeat (TO - 1) tick();
        chk("wd_early", bus.timeout_err, 0);
        chk("wd_busy", bus.busy, 1);
        tick();
        chk("wd_err", bus.timeout_err, 1);
        chk("wd_clr", bus.core_clr, 1);
        chk("wd_idle", bus.busy, 0);
        tick();
        chk("wd_sticky", bus.timeout_err, 1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("wd_cleared", bus.timeout_err, 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
`else
        repeat (200) tick();
        chk("nowd_busy", bus.busy, 1);
        chk("nowd_err", bus.timeout_err, 0);
        chk("nowd_clr", bus.core_clr, 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("nowd_ab", bus.busy, 0);
`endif
        tick();

        // async reset mid-SEND_COL
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (I) tick();
        chk("ar_valid_pre", bus.col_tvalid, 1);
        bus.col_tready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", bus.col_tvalid, 0);
        chk("ar_busy", bus.busy, 0);
        chk("ar_clr", bus.core_clr, 0);
        chk("ar_h_en", bus.h_rd_en, 0);
        tick();
        rst_n = 1'b1;
        bus.col_tready = 1'b1;
        tick();
        chk("ar_idle", bus.busy, 0);
        go_to_wait();
        pulse_res(J);
        chk("ar_run_clr", bus.core_clr, 1);
        chk("ar_run_iter", bus.iter_cnt, 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bp_iter_ctrl.md
# bp_iter_ctrl

Iteration sequencer for the double-precision message-passing core array (I check-row cores, J variable columns, A alphabet entries).
- Loads the I parity-check rows once per run, then streams A alpha-column beats per iteration.
- Collects J per-column result strobes from the floating-point tree, clears the cores between iterations, and stops after MAX_ITER iterations.
- Sits between the host start/abort interface and the datapath top, replacing the datapath's free-running self-restart.

## Interface
- J, default 14: columns per iteration (result strobes expected per iteration)
- I, default 7: H rows to load
- A, default 2: alpha beats per iteration
- MAX_ITER, default 8: iterations per run, ≥1
- TIMEOUT, default 1023: watchdog limit in cycles, used only with the macro
- clk  in  1  clock
- rst_n  in  1  reset: rst_n, asynchronous, active-low; clock clk
- start  in  1  one-cycle run request; ignored unless IDLE
- abort  in  1  synchronous abort; priority over everything except reset
- h_rd_en  out  1  H row read strobe / H_row_tvalid to datapath
- h_rd_addr  out  $clog2(I)+1  row index being loaded
- col_tvalid  out  1  alpha column beat valid
- col_tready  in  1  datapath accepts beat
- col_tlast  out  1  high on beat A-1
- col_idx  out  $clog2(A)+1  alphabet index of current beat
- col_src_sel  out  1  0 = host initial alpha, 1 = feedback alpha
- res_tvalid  in  1  one pulse per finished column result
- core_clr  out  1  one-cycle synchronous clear of core array
- iter_cnt  out  $clog2(MAX_ITER+1)  completed iterations
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on run completion
- timeout_err  out  1  sticky watchdog flag, cleared by next accepted start

## Operation
All outputs are registered. Reset values: all 0; the state is IDLE.
- IDLE: on start, go to LOAD_H, clear iter_cnt, clear timeout_err, clear the row counter.
- LOAD_H: assert h_rd_en for exactly I consecutive cycles with h_rd_addr 0..I-1. After row I-1, go to SEND_COL.
- SEND_COL: hold col_tvalid=1. A beat completes only on col_tvalid && col_tready, which advances col_idx 0..A-1. col_tlast=1 iff col_idx==A-1. col_src_sel=(iter_cnt!=0). After the tlast handshake, drop col_tvalid the next cycle, clear the result counter, and go to WAIT_RES.
- WAIT_RES: count res_tvalid pulses. On the J-th pulse:
  - iter_cnt increments.
  - If the new iter_cnt==MAX_ITER, go to DONE.
  - Otherwise go to CLEAR.
- CLEAR: core_clr=1 for one cycle, then go to SEND_COL.
- DONE: done=1 for one cycle, then go to IDLE. iter_cnt holds its final value until the next start.
- abort in any non-IDLE state:
  - next cycle: core_clr=1, every valid/strobe output is 0, state is IDLE.
  - iter_cnt holds its value.
  - No done pulse is generated.
- res_tvalid outside WAIT_RES is ignored and not counted.
- start while busy is ignored.
- start and abort together in IDLE: abort wins and state stays IDLE.
- Counters saturate at their terminal values; nothing wraps past its limit.

## Timing
- Latency from start to first h_rd_en: 1 cycle.
- LOAD_H lasts exactly I cycles.
- With col_tready held high, SEND_COL lasts exactly A cycles. Deasserting col_tready stretches it with col_idx and col_tvalid held stable (AXI-S rules, no beat dropped or repeated).
- WAIT_RES duration depends on the datapath.
- The J-th res_tvalid produces core_clr or done 1 cycle later.
- After CLEAR, the next col_tvalid follows 1 cycle after core_clr.
- Back-to-back run: start is accepted on the cycle after done, so the first cycle that sees IDLE.
- Async reset mid-run: all outputs go to 0 immediately and no core_clr is generated. The datapath reset is shared.

## Configuration
- BP_ITER_CTRL_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT_RES and restarts on each res_tvalid.
  - If it reaches TIMEOUT, set timeout_err and behave as abort (core_clr pulse, go to IDLE, no done).
- Not defined: no watchdog logic; timeout_err is tied to 0 and WAIT_RES waits indefinitely.

## Test plan
- J=14, I=7, A=2, MAX_ITER=3, col_tready=1, datapath model returns 14 res pulses 20 cycles after each tlast -> h_rd_addr runs 0..6; three 2-beat bursts with col_src_sel 0,1,1; two core_clr pulses; done once; iter_cnt=3.
- col_tready toggled 1,0,0,1 during SEND_COL -> exactly 2 handshakes; col_idx stable while stalled; tlast only on idx 1.
- abort asserted after 5 of 14 results in iteration 1 -> next cycle core_clr=1, busy=0, no done, iter_cnt=1; a following start reruns from LOAD_H with iter_cnt=0.
- Spurious res_tvalid during LOAD_H and SEND_COL plus start pulses while busy -> both ignored; the iteration still needs 14 in-window pulses.
- With BP_ITER_CTRL_TIMEOUT_EN and TIMEOUT=50, 13 results then silence -> timeout_err=1 exactly 50 cycles after the last pulse, core_clr, IDLE. Without the macro -> remains in WAIT_RES, timeout_err=0.
- rst_n asserted mid-SEND_COL -> all outputs 0 asynchronously; after release the block is IDLE and a start produces a normal run.
